// File: rtl/vga_ctrl_conditioner.sv
// Switch conditioner for the VGA demo: synchronise and debounce ui_raw, then apply
// the settled value only at a vsync rise. Also generates frame_tick and frame_cnt.
module vga_ctrl_conditioner #(
  parameter int DEBOUNCE_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ui_raw,
  input  logic        vsync,
  output logic [1:0]  speed_sel,
  output logic [1:0]  palette_sel,
  output logic        scanline_off,
  output logic        frame_tick,
  output logic        cfg_changed,
  output logic [15:0] frame_cnt
);

  localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX = '1;
  localparam logic [DEBOUNCE_BITS-1:0] CNT_ONE = {{(DEBOUNCE_BITS-1){1'b0}}, 1'b1};

  logic [4:0]               sync1_q, sync1_d;
  logic [4:0]               sync2_q, sync2_d;
  logic [4:0]               cand_q, cand_d;
  logic [4:0]               stable_q, stable_d;
  logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
  logic                     vsync_prev_q, vsync_prev_d;
  logic [4:0]               cfg_q, cfg_d;
  logic                     frame_tick_q, frame_tick_d;
  logic                     cfg_changed_q, cfg_changed_d;
  logic [15:0]              frame_cnt_q, frame_cnt_d;
  logic                     rise;

  assign rise = vsync & ~vsync_prev_q;

  always_comb begin
    sync1_d       = ui_raw;
    sync2_d       = sync1_q;
    cand_d        = cand_q;
    stable_d      = stable_q;
    cnt_d         = cnt_q;
    vsync_prev_d  = vsync;
    cfg_d         = cfg_q;
    frame_tick_d  = 1'b0;
    cfg_changed_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;

    // One counter for the whole vector: any bit change restarts the count.
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      stable_d = cand_q;
    end

    // Uses the pre-update stable_q, so a value settling on this edge waits a frame.
    if (rise) begin
      cfg_d         = stable_q;
      frame_tick_d  = 1'b1;
      cfg_changed_d = (stable_q != cfg_q);
      frame_cnt_d   = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      cand_q        <= '0;
      stable_q      <= '0;
      cnt_q         <= '0;
      vsync_prev_q  <= 1'b1;
      cfg_q         <= '0;
      frame_tick_q  <= 1'b0;
      cfg_changed_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      cand_q        <= cand_d;
      stable_q      <= stable_d;
      cnt_q         <= cnt_d;
      vsync_prev_q  <= vsync_prev_d;
      cfg_q         <= cfg_d;
      frame_tick_q  <= frame_tick_d;
      cfg_changed_q <= cfg_changed_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign speed_sel    = cfg_q[1:0];
  assign palette_sel  = cfg_q[3:2];
  assign scanline_off = cfg_q[4];
  assign frame_tick   = frame_tick_q;
  assign cfg_changed  = cfg_changed_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_vga_ctrl_conditioner.sv
// Directed bench for vga_ctrl_conditioner (DEBOUNCE_BITS=4, MAX=15).
module tb_vga_ctrl_conditioner;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ui_raw;
  logic        vsync;
  logic [1:0]  speed_sel;
  logic [1:0]  palette_sel;
  logic        scanline_off;
  logic        frame_tick;
  logic        cfg_changed;
  logic [15:0] frame_cnt;

  int n_pass  = 0;
  int n_total = 0;

  vga_ctrl_conditioner #(.DEBOUNCE_BITS(4)) dut (
    .clk(clk), .reset(reset), .ui_raw(ui_raw), .vsync(vsync),
    .speed_sel(speed_sel), .palette_sel(palette_sel), .scanline_off(scanline_off),
    .frame_tick(frame_tick), .cfg_changed(cfg_changed), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Packed view of all outputs: {speed,palette,scan,tick,chg,cnt}.
  function automatic logic [31:0] outs();
    return {9'd0, speed_sel, palette_sel, scanline_off, frame_tick, cfg_changed, frame_cnt};
  endfunction

  function automatic logic [31:0] exp_outs(input logic [1:0] sp, input logic [1:0] pal,
                                           input logic sc, input logic ft, input logic cc,
                                           input logic [15:0] fc);
    return {9'd0, sp, pal, sc, ft, cc, fc};
  endfunction

  task automatic frame();
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
  endtask

  initial begin
    int bad;
    int ticks_seen;
    int wide;

    // Reset then idle
    reset = 1'b1; vsync = 1'b1; ui_raw = 5'b00000;
    tick(3);
    reset = 1'b0;
    chk("reset_outputs", outs(), 32'd0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (outs() !== 32'd0) bad++;
    end
    chk("idle_100_cycles_quiet", bad, 0);

    // Debounce latency: stable updates at edge k+18, not k+17
    ui_raw = 5'b10110;
    tick(18);
    chk("stable_not_yet_k17", dut.stable_q, 5'b00000);
    tick();
    chk("stable_at_k18", dut.stable_q, 5'b10110);
    chk("no_apply_before_frame", outs(), 32'd0);
    frame();
    chk("first_frame_apply", outs(), exp_outs(2'b10, 2'b01, 1'b1, 1'b1, 1'b1, 16'd1));
    tick();
    chk("tick_one_cycle", outs(), exp_outs(2'b10, 2'b01, 1'b1, 1'b0, 1'b0, 16'd1));

    // Glitch rejection: 10-cycle pulse on bit0 never reaches stable
    ui_raw = 5'b10111;
    tick(10);
    ui_raw = 5'b10110;
    tick(25);
    chk("glitch_stable_unchanged", dut.stable_q, 5'b10110);
    frame();
    chk("glitch_frame_no_change", outs(), exp_outs(2'b10, 2'b01, 1'b1, 1'b1, 1'b0, 16'd2));

    // Mid-frame change held until the vsync rise
    vsync = 1'b0;
    tick();
    ui_raw = 5'b00011;
    tick(25);
    chk("midframe_stable_settled", dut.stable_q, 5'b00011);
    chk("midframe_outputs_held", outs(), exp_outs(2'b10, 2'b01, 1'b1, 1'b0, 1'b0, 16'd2));
    vsync = 1'b1;
    tick();
    chk("midframe_apply_at_rise", outs(), exp_outs(2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 16'd3));
    frame();
    chk("same_value_no_change", outs(), exp_outs(2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 16'd4));

    // Stable update on the same edge as a rise: old stable is applied
    vsync = 1'b0;
    ui_raw = 5'b01100;
    tick(18);
    vsync = 1'b1;
    tick();
    chk("simul_stable_updated", dut.stable_q, 5'b01100);
    chk("simul_old_value_applied", outs(), exp_outs(2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 16'd5));
    frame();
    chk("simul_new_next_frame", outs(), exp_outs(2'b00, 2'b11, 1'b0, 1'b1, 1'b1, 16'd6));

    // Reset mid-debounce, released with vsync high
    ui_raw = 5'b11111;
    tick(8);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_outputs", outs(), 32'd0);
    chk("midreset_stable", dut.stable_q, 5'b00000);
    bad = 0;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (frame_tick !== 1'b0) bad++;
    end
    chk("post_reset_not_settled", dut.stable_q, 5'b00000);
    tick();
    if (frame_tick !== 1'b0) bad++;
    chk("post_reset_settled", dut.stable_q, 5'b11111);
    chk("no_tick_vsync_high_at_release", bad, 0);
    frame();
    chk("post_reset_frame", outs(), exp_outs(2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 16'd1));

    // Frame counter wrap over 65536 pulses
    ui_raw = 5'b00000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ticks_seen = 0;
    wide = 0;
    for (int i = 0; i < 65536; i++) begin
      vsync = 1'b0;
      tick();
      if (frame_tick !== 1'b0) wide++;
      vsync = 1'b1;
      tick();
      if (frame_tick === 1'b1) ticks_seen++;
      if (i == 65534) chk("cnt_at_ffff", frame_cnt, 16'hFFFF);
    end
    chk("cnt_wrapped_to_zero", frame_cnt, 16'd0);
    chk("tick_count_65536", ticks_seen, 65536);
    chk("tick_width_one", wide, 0);
    tick();
    chk("tick_clear_after_wrap", frame_tick, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
